cpu_control_sequencer: RTL and testbench
========================================

Name: cpu_control_sequencer

Overview:
- Hardwired Moore control unit that sequences the 32-bit bus datapath through fetch and execute timing steps.
- Drives every bus-out select, register-in enable, ALU op and memory Read strobe. Also owns the instruction register (IR) and a retired-instruction counter.
- Sits beside the datapath. The integrator wires Rout[i]/Rin[i] to the datapath's R<i>out/R<i>in.

Parameters:
- MEM_WAIT_MAX, 15, max cycles T1 may stall on mem_ready before FAULT (1..255)
- CNT_W, 16, width of the retired counter

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; leaves IDLE
- bus  in  32  datapath BusMuxOut; IR loads from it
- mem_ready  in  1  memory read data valid on MDataIn
- Rout  out  16  one-hot GPR bus-out select
- Rin  out  16  one-hot GPR load enable
- HIin, LOin, HIout, LOout  out  1 each  HI/LO register control
- Zhighin, Zlowin, Zhighout, Zlowout  out  1 each  Z register control
- PCout, PCin, MDRout, MDRin, Yin, Read, IRin  out  1 each  datapath control
- op  out  5  ALU operation
- ir  out  32  current instruction
- halted  out  1  in HALTED state
- fault  out  1  in FAULT state
- illegal  out  1  sticky; unknown opcode seen
- retired  out  CNT_W  instructions completed

Behaviour:
- IR format: opcode=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15].
- Opcode classes:
  - 0x00–0x0B: three-register ALU.
  - 0x0F MUL, 0x10 DIV: ra, rb; result to HI/LO.
  - 0x1A NOP.
  - 0x1B HALT.
  - Anything else: illegal; executes as NOP and sets illegal.
- States: IDLE, T0..T6, HALTED, FAULT. Outputs are decoded combinationally from the registered state and IR only; no input reaches an output combinationally.
- Reset (clear=0 at an edge), from any state including mid-instruction:
  - state=IDLE; IR, retired, illegal and the wait counter all 0.
  - All strobes 0, op=0, halted=0, fault=0.
- IDLE: all strobes 0. start=1 -> T0. Otherwise stay.
- Fetch:
  - T0: PCout, Yin=0, op=OP_INCPC (0x1F, bus+1), Zlowin.
  - T1: Zlowout, PCin, Read, MDRin. Stays in T1 while mem_ready=0, counting wait cycles.
    - mem_ready=1 -> T2.
    - Wait count reaching MEM_WAIT_MAX with mem_ready still 0 -> FAULT.
    - PCin is asserted only in the first T1 cycle, so PC increments exactly once.
  - T2: MDRout, IRin. IR <= bus at the end of T2.
- Three-register ALU:
  - T3: Rout[rb], Yin.
  - T4: Rout[rc], op=opcode, Zlowin, Zhighin.
  - T5: Zlowout, Rin[ra]. Instruction complete.
- MUL/DIV:
  - T3: Rout[ra], Yin.
  - T4: Rout[rb], op=opcode, Zlowin, Zhighin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin. Instruction complete.
- NOP/illegal: complete at T3 with no strobes.
- HALT: T3 -> HALTED; halted=1. Only reset leaves HALTED.
- Completion: retired += 1 (wraps modulo 2^CNT_W) and next state is T0, back-to-back. start is ignored outside IDLE.
- FAULT: all strobes 0, fault=1. Only reset leaves FAULT; retired is not incremented.
- Invariants: at most one bus-out source per cycle, and Rout/Rin are each one-hot or zero.
- ra=rb or rb=rc is legal; there are no hazards, because each step is a distinct bus cycle.

Optional Feature:
- Macro: CTRL_SINGLE_STEP_EN.
- Defined: adds input step (1 bit).
  - Every state transition out of T0..T6 additionally requires step=1. Otherwise the state holds and all strobes are forced to 0.
  - The T1 wait counter advances only on cycles with step=1.
  - IDLE, HALTED and FAULT behave as without the macro.
- Undefined: no step port; the controller free-runs as above.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams: OP_ADD..OP_0B, OP_MUL=0x0F, OP_DIV=0x10, OP_NOP=0x1A, OP_HALT=0x1B, OP_INCPC=0x1F
  - state encoding typedef
  - IR field bit positions
- One sub-module is natural: ctrl_decode (combinational state+IR -> strobe vector, including the 4-to-16 one-hot decoders).
- The top level keeps the state register, IR, wait counter and retired counter.

Test Plan:
- Reset mid-T4 (clear=0 for one edge) -> next cycle state IDLE, all strobes 0, retired=0, illegal=0.
- start with mem_ready=1, IR=ADD ra=3 rb=1 rc=2 -> T0..T5 in exactly 6 cycles. T5 shows Zlowout=1, Rin=16'h0008. Then T0 again and retired=1.
- MUL ra=4 rb=5 -> T5 LOin=1, T6 HIin=1, Rout=16'h0010 in T3, 16'h0020 in T4.
- mem_ready held low 3 cycles, MEM_WAIT_MAX=15 -> T1 lasts 4 cycles, PCin high only in the first. mem_ready held low 15 cycles -> fault=1 and stays until reset.
- Opcode 0x14 -> illegal=1 after T2, completes at T3, retired increments. HALT -> halted=1 and start is ignored.
- With CTRL_SINGLE_STEP_EN, step low 5 cycles in T3 -> state holds, strobes 0. One step pulse -> advances to T4.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, IR field
// positions, state encoding and the control-strobe bundle.
package ctrl_pkg;

  localparam logic [4:0] OP_ADD   = 5'h00;
  localparam logic [4:0] OP_0B    = 5'h0B;
  localparam logic [4:0] OP_MUL   = 5'h0F;
  localparam logic [4:0] OP_DIV   = 5'h10;
  localparam logic [4:0] OP_NOP   = 5'h1A;
  localparam logic [4:0] OP_HALT  = 5'h1B;
  localparam logic [4:0] OP_INCPC = 5'h1F;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  localparam int WAIT_W = 8;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_HALTED = 4'd8,
    S_FAULT  = 4'd9
  } state_e;

  typedef struct packed {
    logic [15:0] rout;
    logic [15:0] rin;
    logic [4:0]  op;
    logic        hiin;
    logic        loin;
    logic        hiout;
    logic        loout;
    logic        zhighin;
    logic        zlowin;
    logic        zhighout;
    logic        zlowout;
    logic        pcout;
    logic        pcin;
    logic        mdrout;
    logic        mdrin;
    logic        yin;
    logic        read;
    logic        irin;
    logic        halted;
    logic        fault;
  } ctrl_t;

  function automatic logic is_alu3(input logic [4:0] opc);
    return (opc <= OP_0B);
  endfunction

  function automatic logic is_muldiv(input logic [4:0] opc);
    return (opc == OP_MUL) || (opc == OP_DIV);
  endfunction

  function automatic logic is_known(input logic [4:0] opc);
    return is_alu3(opc) || is_muldiv(opc) || (opc == OP_NOP) || (opc == OP_HALT);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Moore output decode: registered state + IR -> full strobe bundle,
// including the 4-to-16 one-hot register selects.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_e      state_i,
  input  logic [31:0] ir_i,
  input  logic        first_t1_i,
  output ctrl_t       ctrl_o
);

  logic [4:0]  opc_s;
  logic [15:0] ra_oh_s;
  logic [15:0] rb_oh_s;
  logic [15:0] rc_oh_s;
  logic        unused_ir_s;

  assign opc_s       = ir_i[OPC_MSB:OPC_LSB];
  assign ra_oh_s     = 16'h0001 << ir_i[RA_MSB:RA_LSB];
  assign rb_oh_s     = 16'h0001 << ir_i[RB_MSB:RB_LSB];
  assign rc_oh_s     = 16'h0001 << ir_i[RC_MSB:RC_LSB];
  assign unused_ir_s = ^ir_i[RC_LSB-1:0];

  // Strobe decode per timing step
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_T0: begin
        ctrl_o.pcout  = 1'b1;
        ctrl_o.zlowin = 1'b1;
        ctrl_o.op     = OP_INCPC;
      end
      S_T1: begin
        // PC is reloaded only once however long memory stalls
        ctrl_o.zlowout = 1'b1;
        ctrl_o.pcin    = first_t1_i;
        ctrl_o.read    = 1'b1;
        ctrl_o.mdrin   = 1'b1;
      end
      S_T2: begin
        ctrl_o.mdrout = 1'b1;
        ctrl_o.irin   = 1'b1;
      end
      S_T3: begin
        if (is_alu3(opc_s)) begin
          ctrl_o.rout = rb_oh_s;
          ctrl_o.yin  = 1'b1;
        end else if (is_muldiv(opc_s)) begin
          ctrl_o.rout = ra_oh_s;
          ctrl_o.yin  = 1'b1;
        end else begin
          ctrl_o.yin = 1'b0;
        end
      end
      S_T4: begin
        if (is_alu3(opc_s) || is_muldiv(opc_s)) begin
          ctrl_o.rout    = is_alu3(opc_s) ? rc_oh_s : rb_oh_s;
          ctrl_o.op      = opc_s;
          ctrl_o.zlowin  = 1'b1;
          ctrl_o.zhighin = 1'b1;
        end else begin
          ctrl_o.op = 5'h00;
        end
      end
      S_T5: begin
        ctrl_o.zlowout = 1'b1;
        if (is_muldiv(opc_s)) begin
          ctrl_o.loin = 1'b1;
        end else begin
          ctrl_o.rin = ra_oh_s;
        end
      end
      S_T6: begin
        ctrl_o.zhighout = 1'b1;
        ctrl_o.hiin     = 1'b1;
      end
      S_HALTED: ctrl_o.halted = 1'b1;
      S_FAULT:  ctrl_o.fault  = 1'b1;
      default:  ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Hardwired control sequencer: state register, IR, T1 wait counter and retired
// counter. Optional single-step gating is enabled by macro CTRL_SINGLE_STEP_EN.
module cpu_control_sequencer
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [31:0]      bus,
  input  logic             mem_ready,
  output logic [15:0]      Rout,
  output logic [15:0]      Rin,
  output logic             HIin,
  output logic             LOin,
  output logic             HIout,
  output logic             LOout,
  output logic             Zhighin,
  output logic             Zlowin,
  output logic             Zhighout,
  output logic             Zlowout,
  output logic             PCout,
  output logic             PCin,
  output logic             MDRout,
  output logic             MDRin,
  output logic             Yin,
  output logic             Read,
  output logic             IRin,
  output logic [4:0]       op,
  output logic [31:0]      ir,
  output logic             halted,
  output logic             fault,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  state_e             state_q, state_d;
  logic [31:0]        ir_q, ir_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               illegal_q, illegal_d;
  logic               advance_s;
  logic [4:0]         opc_s;
  ctrl_t              dec_s;
  ctrl_t              ctrl_s;

  assign opc_s = ir_q[OPC_MSB:OPC_LSB];

`ifdef CTRL_SINGLE_STEP_EN
  assign advance_s = !(state_q inside {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6}) || step;
`else
  assign advance_s = 1'b1;
`endif

  // Next-state, IR capture, wait and retire counting
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    if (advance_s) begin
      case (state_q)
        S_IDLE: state_d = start ? S_T0 : S_IDLE;
        S_T0: begin
          state_d = S_T1;
          wait_d  = '0;
        end
        S_T1: begin
          if (mem_ready) begin
            state_d = S_T2;
          end else if (wait_q >= WAIT_LAST) begin
            state_d = S_FAULT;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        S_T2: begin
          state_d   = S_T3;
          ir_d      = bus;
          illegal_d = illegal_q | !is_known(bus[OPC_MSB:OPC_LSB]);
        end
        S_T3: begin
          if (is_alu3(opc_s) || is_muldiv(opc_s)) begin
            state_d = S_T4;
          end else if (opc_s == OP_HALT) begin
            state_d = S_HALTED;
          end else begin
            state_d   = S_T0;
            retired_d = retired_q + CNT_W'(1);
          end
        end
        S_T4: state_d = S_T5;
        S_T5: begin
          if (is_muldiv(opc_s)) begin
            state_d = S_T6;
          end else begin
            state_d   = S_T0;
            retired_d = retired_q + CNT_W'(1);
          end
        end
        S_T6: begin
          state_d   = S_T0;
          retired_d = retired_q + CNT_W'(1);
        end
        S_HALTED: state_d = S_HALTED;
        S_FAULT:  state_d = S_FAULT;
        default:  state_d = S_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and datapath-owned registers, synchronous active-low clear
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  ctrl_decode u_decode (
    .state_i    (state_q),
    .ir_i       (ir_q),
    .first_t1_i (wait_q == '0),
    .ctrl_o     (dec_s)
  );

  // Stalled single-step cycles must not strobe the datapath
  always_comb begin
    if (advance_s) begin
      ctrl_s = dec_s;
    end else begin
      ctrl_s = '0;
    end
  end

  assign Rout     = ctrl_s.rout;
  assign Rin      = ctrl_s.rin;
  assign op       = ctrl_s.op;
  assign HIin     = ctrl_s.hiin;
  assign LOin     = ctrl_s.loin;
  assign HIout    = ctrl_s.hiout;
  assign LOout    = ctrl_s.loout;
  assign Zhighin  = ctrl_s.zhighin;
  assign Zlowin   = ctrl_s.zlowin;
  assign Zhighout = ctrl_s.zhighout;
  assign Zlowout  = ctrl_s.zlowout;
  assign PCout    = ctrl_s.pcout;
  assign PCin     = ctrl_s.pcin;
  assign MDRout   = ctrl_s.mdrout;
  assign MDRin    = ctrl_s.mdrin;
  assign Yin      = ctrl_s.yin;
  assign Read     = ctrl_s.read;
  assign IRin     = ctrl_s.irin;
  assign halted   = ctrl_s.halted;
  assign fault    = ctrl_s.fault;
  assign ir       = ir_q;
  assign illegal  = illegal_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Directed, table-driven bench for cpu_control_sequencer.
module tb_cpu_control_sequencer;

  logic        clock = 1'b0;
  logic        clear, start, mem_ready, step;
  logic [31:0] bus;
  logic [15:0] Rout, Rin;
  logic        HIin, LOin, HIout, LOout, Zhighin, Zlowin, Zhighout, Zlowout;
  logic        PCout, PCin, MDRout, MDRin, Yin, Read, IRin;
  logic [4:0]  op;
  logic [31:0] ir;
  logic        halted, fault, illegal;
  logic [15:0] retired;
  logic [16:0] flags;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  cpu_control_sequencer #(.MEM_WAIT_MAX(15), .CNT_W(16)) dut (
    .clock(clock), .clear(clear), .start(start),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .bus(bus), .mem_ready(mem_ready),
    .Rout(Rout), .Rin(Rin), .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
    .Zhighin(Zhighin), .Zlowin(Zlowin), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .PCin(PCin), .MDRout(MDRout), .MDRin(MDRin), .Yin(Yin),
    .Read(Read), .IRin(IRin), .op(op), .ir(ir), .halted(halted), .fault(fault),
    .illegal(illegal), .retired(retired)
  );

  assign flags = {HIin, LOin, HIout, LOout, Zhighin, Zlowin, Zhighout, Zlowout,
                  PCout, PCin, MDRout, MDRin, Yin, Read, IRin, halted, fault};

  localparam logic [16:0] F_HIIN  = 17'h10000, F_LOIN   = 17'h08000;
  localparam logic [16:0] F_ZHIN  = 17'h01000, F_ZLIN   = 17'h00800;
  localparam logic [16:0] F_ZHOUT = 17'h00400, F_ZLOUT  = 17'h00200;
  localparam logic [16:0] F_PCOUT = 17'h00100, F_PCIN   = 17'h00080;
  localparam logic [16:0] F_MDROUT= 17'h00040, F_MDRIN  = 17'h00020;
  localparam logic [16:0] F_YIN   = 17'h00010, F_READ   = 17'h00008;
  localparam logic [16:0] F_IRIN  = 17'h00004, F_HALT   = 17'h00002;
  localparam logic [16:0] F_FAULT = 17'h00001, F_NONE   = 17'h00000;
  localparam logic [16:0] FT0 = F_PCOUT | F_ZLIN;
  localparam logic [16:0] FT1 = F_ZLOUT | F_PCIN | F_READ | F_MDRIN;
  localparam logic [16:0] FT2 = F_MDROUT | F_IRIN;

  localparam logic [31:0] I_ADD = 32'h01890000;  // ADD ra=3 rb=1 rc=2
  localparam logic [31:0] I_MUL = 32'h7A280000;  // MUL ra=4 rb=5
  localparam logic [31:0] I_ILL = 32'hA0000000;  // opcode 0x14
  localparam logic [31:0] I_HLT = 32'hD8000000;  // HALT

  typedef struct {
    logic        start;
    logic        mr;
    logic [31:0] bus;
    logic [15:0] rout;
    logic [15:0] rin;
    logic [4:0]  op;
    logic [16:0] flags;
    logic [15:0] ret;
    logic        ill;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic s, input logic [31:0] b, input logic [15:0] ro,
                     input logic [15:0] ri, input logic [4:0] o, input logic [16:0] f,
                     input logic [15:0] rt, input logic il);
    vec_t v;
    v.start = s; v.mr = 1'b1; v.bus = b; v.rout = ro; v.rin = ri;
    v.op = o; v.flags = f; v.ret = rt; v.ill = il;
    tbl.push_back(v);
  endtask

  task automatic do_reset;
    clear = 1'b0;
    tick;
    clear = 1'b1;
  endtask

  initial begin
    clear = 1'b0; start = 1'b0; mem_ready = 1'b1; step = 1'b1; bus = I_ADD;
    tick;
    tick;
    clear = 1'b1;
    chk("reset_flags", 32'(flags), 32'(F_NONE));
    chk("reset_op", 32'(op), 32'h0);
    chk("reset_retired", 32'(retired), 32'h0);
    chk("reset_ir", ir, 32'h0);
    chk("reset_illegal", 32'(illegal), 32'h0);

    // ADD, MUL, illegal, HALT back-to-back; each row = state after one edge
    add(1'b1, I_ADD, 16'h0000, 16'h0000, 5'h1F, FT0,              16'd0, 1'b0);
    add(1'b0, I_ADD, 16'h0000, 16'h0000, 5'h00, FT1,              16'd0, 1'b0);
    add(1'b0, I_ADD, 16'h0000, 16'h0000, 5'h00, FT2,              16'd0, 1'b0);
    add(1'b0, I_ADD, 16'h0002, 16'h0000, 5'h00, F_YIN,            16'd0, 1'b0);
    add(1'b0, I_ADD, 16'h0004, 16'h0000, 5'h00, F_ZLIN | F_ZHIN,  16'd0, 1'b0);
    add(1'b0, I_ADD, 16'h0000, 16'h0008, 5'h00, F_ZLOUT,          16'd0, 1'b0);
    add(1'b0, I_MUL, 16'h0000, 16'h0000, 5'h1F, FT0,              16'd1, 1'b0);
    add(1'b0, I_MUL, 16'h0000, 16'h0000, 5'h00, FT1,              16'd1, 1'b0);
    add(1'b0, I_MUL, 16'h0000, 16'h0000, 5'h00, FT2,              16'd1, 1'b0);
    add(1'b0, I_MUL, 16'h0010, 16'h0000, 5'h00, F_YIN,            16'd1, 1'b0);
    add(1'b0, I_MUL, 16'h0020, 16'h0000, 5'h0F, F_ZLIN | F_ZHIN,  16'd1, 1'b0);
    add(1'b0, I_MUL, 16'h0000, 16'h0000, 5'h00, F_ZLOUT | F_LOIN, 16'd1, 1'b0);
    add(1'b0, I_MUL, 16'h0000, 16'h0000, 5'h00, F_ZHOUT | F_HIIN, 16'd1, 1'b0);
    add(1'b0, I_ILL, 16'h0000, 16'h0000, 5'h1F, FT0,              16'd2, 1'b0);
    add(1'b0, I_ILL, 16'h0000, 16'h0000, 5'h00, FT1,              16'd2, 1'b0);
    add(1'b0, I_ILL, 16'h0000, 16'h0000, 5'h00, FT2,              16'd2, 1'b0);
    add(1'b0, I_ILL, 16'h0000, 16'h0000, 5'h00, F_NONE,           16'd2, 1'b1);
    add(1'b0, I_HLT, 16'h0000, 16'h0000, 5'h1F, FT0,              16'd3, 1'b1);
    add(1'b0, I_HLT, 16'h0000, 16'h0000, 5'h00, FT1,              16'd3, 1'b1);
    add(1'b0, I_HLT, 16'h0000, 16'h0000, 5'h00, FT2,              16'd3, 1'b1);
    add(1'b0, I_HLT, 16'h0000, 16'h0000, 5'h00, F_NONE,           16'd3, 1'b1);
    add(1'b0, I_HLT, 16'h0000, 16'h0000, 5'h00, F_HALT,           16'd3, 1'b1);
    add(1'b1, I_HLT, 16'h0000, 16'h0000, 5'h00, F_HALT,           16'd3, 1'b1);
    add(1'b0, I_HLT, 16'h0000, 16'h0000, 5'h00, F_HALT,           16'd3, 1'b1);

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].start; mem_ready = tbl[i].mr; bus = tbl[i].bus;
      tick;
      chk($sformatf("v%0d_rout", i),    32'(Rout),    32'(tbl[i].rout));
      chk($sformatf("v%0d_rin", i),     32'(Rin),     32'(tbl[i].rin));
      chk($sformatf("v%0d_op", i),      32'(op),      32'(tbl[i].op));
      chk($sformatf("v%0d_flags", i),   32'(flags),   32'(tbl[i].flags));
      chk($sformatf("v%0d_retired", i), 32'(retired), 32'(tbl[i].ret));
      chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(tbl[i].ill));
    end
    chk("halt_ir", ir, I_HLT);

    // Reset out of HALTED, then reset mid-T4
    do_reset;
    chk("rst_halt_flags", 32'(flags), 32'(F_NONE));
    chk("rst_halt_retired", 32'(retired), 32'h0);
    chk("rst_halt_illegal", 32'(illegal), 32'h0);
    bus = I_ADD; start = 1'b1; mem_ready = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    chk("mid_ir", ir, I_ADD);
    tick;
    chk("mid_t4_rout", 32'(Rout), 32'h0004);
    do_reset;
    chk("rst_t4_flags", 32'(flags), 32'(F_NONE));
    chk("rst_t4_rout", 32'(Rout), 32'h0);
    chk("rst_t4_op", 32'(op), 32'h0);
    chk("rst_t4_ir", ir, 32'h0);
    chk("rst_t4_retired", 32'(retired), 32'h0);
    tick;
    chk("idle_hold_flags", 32'(flags), 32'(F_NONE));

    // Memory stall: 3 low cycles -> T1 lasts 4 cycles, PCin only in the first
    start = 1'b1; mem_ready = 1'b0;
    tick;
    start = 1'b0;
    tick;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stall_t1_%0d", k), 32'(flags), 32'((k == 0) ? FT1 : (FT1 & ~F_PCIN)));
      mem_ready = (k == 3);
      tick;
    end
    chk("stall_t2", 32'(flags), 32'(FT2));
    do_reset;

    // Memory timeout: 15 low cycles in T1 -> FAULT, sticky until reset
    start = 1'b1; mem_ready = 1'b0;
    tick;
    start = 1'b0;
    tick;
    repeat (14) tick;
    chk("timeout_t1_15", 32'(flags), 32'(FT1 & ~F_PCIN));
    tick;
    chk("timeout_fault", 32'(flags), 32'(F_FAULT));
    chk("timeout_rout", 32'(Rout), 32'h0);
    mem_ready = 1'b1; start = 1'b1;
    repeat (3) tick;
    start = 1'b0;
    chk("fault_sticky", 32'(flags), 32'(F_FAULT));
    chk("fault_retired", 32'(retired), 32'h0);
    do_reset;
    chk("fault_cleared", 32'(flags), 32'(F_NONE));

`ifdef CTRL_SINGLE_STEP_EN
    // Single step: hold in T3 with strobes gated, then one step to T4
    bus = I_ADD; start = 1'b1; mem_ready = 1'b1; step = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    chk("step_t3_rout", 32'(Rout), 32'h0002);
    step = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk($sformatf("step_hold_rout_%0d", k), 32'(Rout), 32'h0);
      chk($sformatf("step_hold_flags_%0d", k), 32'(flags), 32'(F_NONE));
    end
    step = 1'b1;
    #1;
    chk("step_t3_again", 32'(Rout), 32'h0002);
    tick;
    chk("step_t4_rout", 32'(Rout), 32'h0004);
    chk("step_t4_flags", 32'(flags), 32'(F_ZLIN | F_ZHIN));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
